// File: rtl/pd_pkg.sv
// Shared definitions for the power-down entry handshake: state encoding and
// default timing used by the sequencer, power manager and scheduler.
package pd_pkg;

   typedef enum logic [2:0] {
      ST_ACTIVE = 3'd0,
      ST_REQ    = 3'd1,
      ST_ENTER  = 3'd2,
      ST_PD     = 3'd3,
      ST_EXIT   = 3'd4
   } pd_state_e;

   localparam int T_CKE       = 4;
   localparam int T_XP        = 6;
   localparam int T_PD_MIN    = 16;
   localparam int REQ_TIMEOUT = 32;
   localparam int CNT_W       = 16;

   // One spare bit above the longest phase length.
   function automatic int timer_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pd_timer.sv
// Loadable down-counter shared by all timed phases of the sequencer.
// Loaded with (phase length - 1) on every state change; holds at zero, so the
// terminal-count flag also serves as a saturating "minimum elapsed" flag.
module pd_timer #(
   parameter int W = 6
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q;

   // Reload on phase change, otherwise count down and stick at zero.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/pd_entry_sequencer.sv
// Power-down entry sequencer: requests power-down from the manager, then
// walks CKE through entry, residency and exit while stalling the scheduler.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ACTIVE | normal operation, watching for entry eligibility
// REQ    | enter_power_down raised, waiting for pd_entered
// ENTER  | CKE low, waiting T_CKE before residency
// PD     | powered down; exits on late command or pd_entered drop
// EXIT   | CKE high again, waiting T_XP before releasing scheduler
module pd_entry_sequencer #(
   parameter int T_CKE       = pd_pkg::T_CKE,
   parameter int T_XP        = pd_pkg::T_XP,
   parameter int T_PD_MIN    = pd_pkg::T_PD_MIN,
   parameter int REQ_TIMEOUT = pd_pkg::REQ_TIMEOUT,
   parameter int CNT_W       = pd_pkg::CNT_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             pd_enable,
   input  logic             thermal_low_power,
   input  logic             pd_ready,
   input  logic             pd_entered,
   input  logic             cmd_pending,
   output logic             enter_power_down,
   output logic             cke,
   output logic             cmd_block,
   output logic             wake_done,
   output logic [2:0]       seq_state,
   output logic [CNT_W-1:0] pd_count
);

   localparam int TW = pd_pkg::timer_width(T_CKE, T_XP, T_PD_MIN, REQ_TIMEOUT);

   localparam logic [TW-1:0] LD_REQ   = TW'(REQ_TIMEOUT - 1);
   localparam logic [TW-1:0] LD_ENTER = TW'(T_CKE - 1);
   localparam logic [TW-1:0] LD_PD    = TW'(T_PD_MIN - 1);
   localparam logic [TW-1:0] LD_EXIT  = TW'(T_XP - 1);

   pd_pkg::pd_state_e state_q, state_d;
   logic              timer_load;
   logic [TW-1:0]     timer_val;
   logic              timer_tc;
   logic              eligible;
   logic [CNT_W-1:0]  pd_count_q;
   logic              wake_q;

   assign eligible = pd_ready & ~cmd_pending & (pd_enable | thermal_low_power);

   // State register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         state_q <= pd_pkg::ST_ACTIVE;
      else
         state_q <= state_d;
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      state_d          = state_q;
      cke              = 1'b1;
      cmd_block        = 1'b0;
      enter_power_down = 1'b0;
      case (state_q)
         pd_pkg::ST_ACTIVE: begin
            if (eligible) state_d = pd_pkg::ST_REQ;
         end
         pd_pkg::ST_REQ: begin
            enter_power_down = 1'b1;
            cmd_block        = 1'b1;
            // An acknowledged entry wins over a same-cycle command.
            if (pd_entered)       state_d = pd_pkg::ST_ENTER;
            else if (cmd_pending) state_d = pd_pkg::ST_ACTIVE;
            else if (timer_tc)    state_d = pd_pkg::ST_ACTIVE;
         end
         pd_pkg::ST_ENTER: begin
            cke       = 1'b0;
            cmd_block = 1'b1;
            if (timer_tc) state_d = pd_pkg::ST_PD;
         end
         pd_pkg::ST_PD: begin
            cke       = 1'b0;
            cmd_block = 1'b1;
            if (!pd_entered || (cmd_pending && timer_tc)) state_d = pd_pkg::ST_EXIT;
         end
         pd_pkg::ST_EXIT: begin
            cmd_block = 1'b1;
            if (timer_tc) state_d = pd_pkg::ST_ACTIVE;
         end
         default: state_d = pd_pkg::ST_ACTIVE;
      endcase
   end

   // Phase length for the state being entered.
   always_comb begin
      timer_load = (state_d != state_q);
      timer_val  = '0;
      case (state_d)
         pd_pkg::ST_REQ:   timer_val = LD_REQ;
         pd_pkg::ST_ENTER: timer_val = LD_ENTER;
         pd_pkg::ST_PD:    timer_val = LD_PD;
         pd_pkg::ST_EXIT:  timer_val = LD_EXIT;
         default:          timer_val = '0;
      endcase
   end

   pd_timer #(.W(TW)) u_timer (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .load     (timer_load),
      .load_val (timer_val),
      .tc       (timer_tc)
   );

   // Completed-entry counter, saturating at all-ones.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         pd_count_q <= '0;
      else if (state_q == pd_pkg::ST_ENTER && state_d == pd_pkg::ST_PD && pd_count_q != '1)
         pd_count_q <= pd_count_q + 1'b1;
   end

   // Wake pulse coincides with the first ACTIVE cycle after EXIT.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         wake_q <= 1'b0;
      else
         wake_q <= (state_q == pd_pkg::ST_EXIT) && (state_d == pd_pkg::ST_ACTIVE);
   end

   assign wake_done = wake_q;
   assign seq_state = state_q;
   assign pd_count  = pd_count_q;

endmodule

// File: tb/tb_pd_entry_sequencer.sv
// Self-checking bench for pd_entry_sequencer: a cycle model pushes expected
// outputs into a scoreboard each cycle, plus an eligibility vector table and
// hand-written multi-cycle sequences. A second instance with a 2-bit counter
// exercises saturation.
module tb_pd_entry_sequencer;

   localparam int TCKE   = 4;
   localparam int TXP    = 6;
   localparam int TPD    = 16;
   localparam int REQ_TO = 32;

   localparam int S_ACT = 0, S_REQ = 1, S_ENT = 2, S_PD = 3, S_EXT = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        pd_enable, thermal_low_power, pd_ready, pd_entered, cmd_pending;
   logic        enter_power_down, cke, cmd_block, wake_done;
   logic [2:0]  seq_state;
   logic [15:0] pd_count;
   logic        s_epd, s_cke, s_blk, s_wake;
   logic [2:0]  s_state;
   logic [1:0]  s_count;

   int n_vec = 0;
   int n_err = 0;

   pd_entry_sequencer dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pd_enable(pd_enable),
      .thermal_low_power(thermal_low_power), .pd_ready(pd_ready),
      .pd_entered(pd_entered), .cmd_pending(cmd_pending),
      .enter_power_down(enter_power_down), .cke(cke), .cmd_block(cmd_block),
      .wake_done(wake_done), .seq_state(seq_state), .pd_count(pd_count)
   );

   pd_entry_sequencer #(.CNT_W(2)) dut_sat (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pd_enable(pd_enable),
      .thermal_low_power(thermal_low_power), .pd_ready(pd_ready),
      .pd_entered(pd_entered), .cmd_pending(cmd_pending),
      .enter_power_down(s_epd), .cke(s_cke), .cmd_block(s_blk),
      .wake_done(s_wake), .seq_state(s_state), .pd_count(s_count)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [2:0]  st;
      logic        cke;
      logic        epd;
      logic        blk;
      logic        wake;
      logic [15:0] cnt;
      logic [1:0]  cnt_s;
   } exp_t;

   exp_t sb[$];

   int          m_st, m_tmr;
   logic        m_wake;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_st = S_ACT; m_tmr = 0; m_wake = 1'b0; m_cnt = '0; m_cnt_s = '0;
   endfunction

   // Reference behaviour written as an up-counting residency timer.
   function automatic void model_step();
      int nx;
      nx = m_st;
      case (m_st)
         S_ACT: if (pd_ready && !cmd_pending && (pd_enable || thermal_low_power)) nx = S_REQ;
         S_REQ: begin
            if (pd_entered)                nx = S_ENT;
            else if (cmd_pending)          nx = S_ACT;
            else if (m_tmr == REQ_TO - 1)  nx = S_ACT;
         end
         S_ENT: if (m_tmr == TCKE - 1) nx = S_PD;
         S_PD:  if (!pd_entered || (cmd_pending && m_tmr >= TPD - 1)) nx = S_EXT;
         S_EXT: if (m_tmr == TXP - 1) nx = S_ACT;
         default: nx = S_ACT;
      endcase
      m_wake = (m_st == S_EXT && nx == S_ACT);
      if (m_st == S_ENT && nx == S_PD) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_cnt_s != 2'b11)  m_cnt_s = m_cnt_s + 2'd1;
      end
      if (nx != m_st)                            m_tmr = 0;
      else if (m_st == S_PD && m_tmr >= TPD - 1) m_tmr = TPD - 1;
      else                                       m_tmr = m_tmr + 1;
      m_st = nx;
   endfunction

   // One clock: predict, push, clock, pop and compare; returns at negedge.
   task automatic tick();
      exp_t e;
      model_step();
      e.st    = 3'(m_st);
      e.cke   = !(m_st == S_ENT || m_st == S_PD);
      e.epd   = (m_st == S_REQ);
      e.blk   = (m_st != S_ACT);
      e.wake  = m_wake;
      e.cnt   = m_cnt;
      e.cnt_s = m_cnt_s;
      sb.push_back(e);
      @(posedge sys_clk);
      #1;
      e = sb.pop_front();
      chk("sb_state", 32'(seq_state), 32'(e.st));
      chk("sb_cke", 32'(cke), 32'(e.cke));
      chk("sb_epd", 32'(enter_power_down), 32'(e.epd));
      chk("sb_block", 32'(cmd_block), 32'(e.blk));
      chk("sb_wake", 32'(wake_done), 32'(e.wake));
      chk("sb_count", 32'(pd_count), 32'(e.cnt));
      chk("sb_sat_count", 32'(s_count), 32'(e.cnt_s));
      @(negedge sys_clk);
   endtask

   task automatic wait_state(input int st, input int max, input string name);
      int n;
      n = 0;
      while (int'(seq_state) != st && n < max) begin
         tick();
         n++;
      end
      chk(name, 32'(seq_state), 32'(st));
   endtask

   task automatic count_state(input int st, input int max, output int n);
      n = 0;
      while (int'(seq_state) == st && n < max) begin
         tick();
         n++;
      end
   endtask

   task automatic idle_inputs();
      pd_enable = 0; thermal_low_power = 0; pd_ready = 0; pd_entered = 0; cmd_pending = 0;
   endtask

   // Drive from ACTIVE into ENTER with a prompt acknowledge.
   task automatic go_to_enter(input logic use_thermal);
      pd_enable = !use_thermal; thermal_low_power = use_thermal;
      pd_ready = 1; cmd_pending = 0; pd_entered = 0;
      wait_state(S_REQ, 4, "reach_req");
      pd_entered = 1;
      tick();
      chk("enter_after_ack", 32'(seq_state), S_ENT);
      pd_ready = 0; pd_enable = 0;
   endtask

   typedef struct {
      logic en, th, rdy, cmd;
      int   exp_st;
   } elig_vec_t;

   elig_vec_t ev[8];

   initial begin
      int n;
      ev[0] = '{1'b1, 1'b0, 1'b1, 1'b0, S_REQ};
      ev[1] = '{1'b0, 1'b1, 1'b1, 1'b0, S_REQ};
      ev[2] = '{1'b0, 1'b0, 1'b1, 1'b0, S_ACT};
      ev[3] = '{1'b1, 1'b1, 1'b0, 1'b0, S_ACT};
      ev[4] = '{1'b1, 1'b0, 1'b1, 1'b1, S_ACT};
      ev[5] = '{1'b0, 1'b1, 1'b1, 1'b1, S_ACT};
      ev[6] = '{1'b1, 1'b1, 1'b1, 1'b0, S_REQ};
      ev[7] = '{1'b0, 1'b0, 1'b0, 1'b0, S_ACT};

      idle_inputs();
      model_reset();
      sys_rst = 1;
      #12;
      chk("rst_state", 32'(seq_state), 0);
      chk("rst_cke", 32'(cke), 1);
      chk("rst_epd", 32'(enter_power_down), 0);
      chk("rst_block", 32'(cmd_block), 0);
      chk("rst_wake", 32'(wake_done), 0);
      chk("rst_count", 32'(pd_count), 0);
      @(negedge sys_clk);
      sys_rst = 0;

      // Eligibility table, each vector applied from ACTIVE.
      for (int i = 0; i < 8; i++) begin
         pd_enable = ev[i].en; thermal_low_power = ev[i].th;
         pd_ready = ev[i].rdy; cmd_pending = ev[i].cmd; pd_entered = 0;
         tick();
         chk($sformatf("elig_vec%0d", i), 32'(seq_state), 32'(ev[i].exp_st));
         if (int'(seq_state) != S_ACT) begin
            idle_inputs();
            cmd_pending = 1;
            tick();
            chk($sformatf("elig_abort%0d", i), 32'(seq_state), S_ACT);
         end
         idle_inputs();
      end

      // Abort by command in the second REQ cycle.
      pd_enable = 1; pd_ready = 1;
      tick();
      chk("abort_req1", 32'(seq_state), S_REQ);
      tick();
      chk("abort_req2", 32'(seq_state), S_REQ);
      cmd_pending = 1;
      tick();
      chk("abort_active", 32'(seq_state), S_ACT);
      chk("abort_epd_low", 32'(enter_power_down), 0);
      idle_inputs();
      tick();

      // Timeout; pd_ready dropping in REQ must not abort.
      pd_enable = 1; pd_ready = 1;
      tick();
      pd_ready = 0; pd_enable = 0;
      count_state(S_REQ, 40, n);
      chk("timeout_req_cycles", 32'(n), REQ_TO);
      chk("timeout_active", 32'(seq_state), S_ACT);

      // Normal entry, ack three cycles into REQ, then early command wake.
      pd_enable = 1; pd_ready = 1;
      wait_state(S_REQ, 4, "normal_req");
      tick(); tick();
      pd_entered = 1;
      tick();
      chk("normal_enter", 32'(seq_state), S_ENT);
      pd_ready = 0; pd_enable = 0;
      count_state(S_ENT, 10, n);
      chk("normal_enter_cycles", 32'(n), TCKE);
      chk("normal_pd", 32'(seq_state), S_PD);
      chk("normal_count1", 32'(pd_count), 1);
      repeat (5) tick();
      cmd_pending = 1;
      count_state(S_PD, 30, n);
      chk("early_wake_pd_cycles", 32'(n + 5), TPD);
      pd_entered = 0;
      count_state(S_EXT, 10, n);
      chk("exit_cycles", 32'(n), TXP);
      chk("wake_pulse", 32'(wake_done), 1);
      chk("wake_unblock", 32'(cmd_block), 0);
      tick();
      chk("wake_single", 32'(wake_done), 0);
      idle_inputs();

      // Simultaneous ack and command in REQ: entry wins and completes.
      pd_enable = 1; pd_ready = 1;
      wait_state(S_REQ, 4, "sim_req");
      pd_entered = 1; cmd_pending = 1;
      tick();
      chk("sim_enter", 32'(seq_state), S_ENT);
      pd_ready = 0; pd_enable = 0;
      count_state(S_ENT, 10, n);
      chk("sim_enter_cycles", 32'(n), TCKE);
      count_state(S_PD, 30, n);
      chk("sim_pd_cycles", 32'(n), TPD);
      count_state(S_EXT, 10, n);
      chk("sim_exit_cycles", 32'(n), TXP);
      chk("sim_block_drop", 32'(cmd_block), 0);
      idle_inputs();

      // pd_entered drop forces immediate exit regardless of residency.
      go_to_enter(1'b0);
      wait_state(S_PD, 8, "drop_pd");
      repeat (3) tick();
      pd_entered = 0;
      tick();
      chk("drop_exit", 32'(seq_state), S_EXT);
      wait_state(S_ACT, 10, "drop_active");
      chk("sat_count_full", 32'(s_count), 3);

      // Thermal-forced entry; thermal drop mid-sequence has no effect.
      go_to_enter(1'b1);
      thermal_low_power = 0;
      wait_state(S_PD, 8, "thermal_pd");
      cmd_pending = 1;
      wait_state(S_EXT, 20, "thermal_exit");
      pd_entered = 0;
      wait_state(S_ACT, 10, "thermal_active");
      chk("count_four", 32'(pd_count), 4);
      chk("sat_count_held", 32'(s_count), 3);
      idle_inputs();
      tick();

      // Asynchronous reset in the middle of ENTER.
      go_to_enter(1'b0);
      tick();
      #2;
      sys_rst = 1;
      #1;
      chk("arst_state", 32'(seq_state), 0);
      chk("arst_cke", 32'(cke), 1);
      chk("arst_block", 32'(cmd_block), 0);
      chk("arst_count", 32'(pd_count), 0);
      chk("arst_sat_count", 32'(s_count), 0);
      model_reset();
      idle_inputs();
      #1;
      sys_rst = 0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

endmodule
